// File: rtl/alu_bist.sv
// rtl/alu_bist.sv - built-in self-test initiator for the 32-bit ALU
//
// Purpose: after a start pulse, drives NUM_VEC LFSR-generated operand pairs
// into the ALU with aluc sweeping 0..15, and checks the returned result and
// flags against an internal golden model, one vector per clock.
//
// Ports:
//   i_clk, i_rst                clock, asynchronous active-high reset
//   i_start                     begin a run (accepted in IDLE or DONE only)
//   o_alu_a, o_alu_b, o_alu_aluc  registered ALU operands / opcode
//   i_alu_r, i_alu_zero, i_alu_carry, i_alu_negative, i_alu_overflow
//                               ALU result and flags (combinational ALU)
//   o_busy, o_done, o_pass      run status; done/pass held until next start
//   o_err_count                 saturating count of failing vectors
//   o_fail_a, o_fail_b, o_fail_aluc  first failing vector
//   o_vec_idx                   index of the vector currently on o_alu_*
module alu_bist #(
   parameter int unsigned NUM_VEC = 256,
   parameter logic [31:0] SEED    = 32'hACE12345,
   parameter int unsigned ERR_W   = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   output logic [31:0]      o_alu_a,
   output logic [31:0]      o_alu_b,
   output logic [3:0]       o_alu_aluc,
   input  logic [31:0]      i_alu_r,
   input  logic             i_alu_zero,
   input  logic             i_alu_carry,
   input  logic             i_alu_negative,
   input  logic             i_alu_overflow,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_pass,
   output logic [ERR_W-1:0] o_err_count,
   output logic [31:0]      o_fail_a,
   output logic [31:0]      o_fail_b,
   output logic [3:0]       o_fail_aluc,
   output logic [15:0]      o_vec_idx
);

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DONE} state_t;

   localparam logic [15:0] LAST_IDX = 16'(NUM_VEC - 1);
   // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
   localparam logic [31:0] EFF_SEED = (SEED == 32'h0) ? 32'h1 : SEED;

   function automatic logic [31:0] lfsr_step(input logic [31:0] q);
      return {q[30:0], q[31] ^ q[21] ^ q[1] ^ q[0]};
   endfunction

   state_t             r_state, w_state_next;
   logic [31:0]        r_lfsr, r_a, r_b, r_fail_a, r_fail_b;
   logic [3:0]         r_aluc, r_fail_aluc;
   logic [15:0]        r_vec_idx;
   logic [ERR_W-1:0]   r_err, w_err_next;
   logic               r_busy, r_done, r_pass;
   logic               w_load_first, w_load_next, w_finish;
   logic [31:0]        w_lfsr_src, w_a_next, w_b_next;
   logic [15:0]        w_idx_inc;
   logic [32:0]        w_sum, w_diff;
   logic [4:0]         w_sh;
   logic [31:0]        w_exp_r;
   logic               w_exp_carry, w_exp_ovf, w_chk_carry, w_chk_ovf, w_mis;

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      w_load_first = 1'b0;
      w_load_next  = 1'b0;
      w_finish     = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               w_state_next = S_CHECK;
               w_load_first = 1'b1;
            end
         end
         S_CHECK: begin
            if (r_vec_idx == LAST_IDX) begin
               w_state_next = S_DONE;
               w_finish     = 1'b1;
            end else begin
               w_load_next = 1'b1;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // The LFSR steps twice per vector: first value to a, second to b.
   // A new run restarts from the seed so every run sees the same vectors.
   assign w_lfsr_src = w_load_first ? EFF_SEED : r_lfsr;
   assign w_a_next   = lfsr_step(w_lfsr_src);
   assign w_b_next   = lfsr_step(w_a_next);
   assign w_idx_inc  = r_vec_idx + 16'd1;

   // Golden model of the vector currently presented to the ALU
   assign w_sh   = r_a[4:0];
   assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
   assign w_diff = {1'b0, r_a} - {1'b0, r_b};   // bit 32 is the unsigned borrow

   always_comb begin
      w_exp_r     = 32'h0;
      w_exp_carry = 1'b0;
      w_exp_ovf   = 1'b0;
      w_chk_carry = 1'b0;
      w_chk_ovf   = 1'b0;
      case (r_aluc)
         4'b0000: begin w_exp_r = w_sum[31:0];  w_chk_carry = 1'b1; w_exp_carry = w_sum[32]; end
         4'b0001: begin w_exp_r = w_diff[31:0]; w_chk_carry = 1'b1; w_exp_carry = w_diff[32]; end
         4'b0010: begin
            w_exp_r   = w_sum[31:0];
            w_chk_ovf = 1'b1;
            w_exp_ovf = (r_a[31] == r_b[31]) && (w_sum[31] != r_a[31]);
         end
         4'b0011: begin
            w_exp_r   = w_diff[31:0];
            w_chk_ovf = 1'b1;
            w_exp_ovf = (r_a[31] != r_b[31]) && (w_diff[31] != r_a[31]);
         end
         4'b0100: w_exp_r = r_a & r_b;
         4'b0101: w_exp_r = r_a | r_b;
         4'b0110: w_exp_r = r_a ^ r_b;
         4'b0111: w_exp_r = ~(r_a | r_b);
         4'b1000, 4'b1001: w_exp_r = {r_b[15:0], 16'h0};
         4'b1010: w_exp_r = {31'h0, (r_a < r_b)};
         4'b1011: w_exp_r = {31'h0, ($signed(r_a) < $signed(r_b))};
         4'b1100: w_exp_r = $signed(r_b) >>> w_sh;
         4'b1101: w_exp_r = r_b >> w_sh;
         default: w_exp_r = r_b << w_sh;
      endcase
   end

   assign w_mis = (i_alu_r != w_exp_r)
                | (i_alu_zero != (w_exp_r == 32'h0))
                | (i_alu_negative != w_exp_r[31])
                | (w_chk_carry & (i_alu_carry != w_exp_carry))
                | (w_chk_ovf & (i_alu_overflow != w_exp_ovf));

   assign w_err_next = (w_mis && (r_err != {ERR_W{1'b1}})) ? r_err + 1'b1 : r_err;

   // Datapath and status registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_lfsr      <= EFF_SEED;
         r_a         <= 32'h0;
         r_b         <= 32'h0;
         r_aluc      <= 4'h0;
         r_vec_idx   <= 16'h0;
         r_err       <= '0;
         r_fail_a    <= 32'h0;
         r_fail_b    <= 32'h0;
         r_fail_aluc <= 4'h0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
      end else begin
         if (w_load_first) begin
            r_err       <= '0;
            r_fail_a    <= 32'h0;
            r_fail_b    <= 32'h0;
            r_fail_aluc <= 4'h0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_busy      <= 1'b1;
            r_vec_idx   <= 16'h0;
            r_aluc      <= 4'h0;
            r_a         <= w_a_next;
            r_b         <= w_b_next;
            r_lfsr      <= w_b_next;
         end
         if (r_state == S_CHECK) begin
            r_err <= w_err_next;
            // err_count still zero means this is the first failing vector
            if (w_mis && (r_err == '0)) begin
               r_fail_a    <= r_a;
               r_fail_b    <= r_b;
               r_fail_aluc <= r_aluc;
            end
            if (w_finish) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
               r_pass <= (w_err_next == '0);
            end
            if (w_load_next) begin
               r_vec_idx <= w_idx_inc;
               r_aluc    <= w_idx_inc[3:0];
               r_a       <= w_a_next;
               r_b       <= w_b_next;
               r_lfsr    <= w_b_next;
            end
         end
      end
   end

   assign o_alu_a     = r_a;
   assign o_alu_b     = r_b;
   assign o_alu_aluc  = r_aluc;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_pass      = r_pass;
   assign o_err_count = r_err;
   assign o_fail_a    = r_fail_a;
   assign o_fail_b    = r_fail_b;
   assign o_fail_aluc = r_fail_aluc;
   assign o_vec_idx   = r_vec_idx;

endmodule

// File: tb/tb_alu_bist.sv
// tb/tb_alu_bist.sv - self-checking bench for alu_bist
module tb_alu_bist;

   localparam int NV    = 64;
   localparam int NS    = 16;
   localparam int NCASE = 7;
   localparam logic [31:0] SEED = 32'hACE12345;
   localparam longint MAXS = 64'sd2147483647;
   localparam longint MINS = -64'sd2147483648;
   localparam longint TWO32 = 64'sd4294967296;

   typedef struct packed { logic [31:0] r; logic c; logic v; } alu_t;
   typedef struct { string name; int mode; int exp_err; int first; } case_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start_m, start_s;
   logic [31:0] m_a, m_b, m_r, m_fa, m_fb;
   logic [3:0]  m_aluc, m_faluc;
   logic        m_zero, m_c, m_neg, m_v, m_busy, m_done, m_pass;
   logic [15:0] m_err, m_idx;
   logic [31:0] s_a, s_b, s_fa, s_fb;
   logic [3:0]  s_aluc, s_faluc;
   logic        s_busy, s_done, s_pass;
   logic [1:0]  s_err;
   logic [15:0] s_idx;

   int          fault, cur_row;
   logic [31:0] va [NV];
   logic [31:0] vb [NV];
   logic [3:0]  vop [NV];
   logic [1:0]  bad_kind [NCASE][NV];
   logic [31:0] flip [NCASE];
   case_t       cases [NCASE];
   int          n_tests = 0, n_fail = 0;

   alu_bist #(.NUM_VEC(NV), .SEED(SEED), .ERR_W(16)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_start(start_m),
      .o_alu_a(m_a), .o_alu_b(m_b), .o_alu_aluc(m_aluc),
      .i_alu_r(m_r), .i_alu_zero(m_zero), .i_alu_carry(m_c),
      .i_alu_negative(m_neg), .i_alu_overflow(m_v),
      .o_busy(m_busy), .o_done(m_done), .o_pass(m_pass), .o_err_count(m_err),
      .o_fail_a(m_fa), .o_fail_b(m_fb), .o_fail_aluc(m_faluc), .o_vec_idx(m_idx)
   );

   // Second instance sees an ALU whose output is stuck at zero
   alu_bist #(.NUM_VEC(NS), .SEED(SEED), .ERR_W(2)) u_sat (
      .i_clk(clk), .i_rst(rst), .i_start(start_s),
      .o_alu_a(s_a), .o_alu_b(s_b), .o_alu_aluc(s_aluc),
      .i_alu_r(32'h0), .i_alu_zero(1'b1), .i_alu_carry(1'b0),
      .i_alu_negative(1'b0), .i_alu_overflow(1'b0),
      .o_busy(s_busy), .o_done(s_done), .o_pass(s_pass), .o_err_count(s_err),
      .o_fail_a(s_fa), .o_fail_b(s_fb), .o_fail_aluc(s_faluc), .o_vec_idx(s_idx)
   );

   function automatic logic [31:0] lfsr(input logic [31:0] q);
      return {q[30:0], q[31] ^ q[21] ^ q[1] ^ q[0]};
   endfunction

   // Reference ALU written with plain 64-bit integer arithmetic
   function automatic alu_t ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      longint ua, ub, sa, sb, t;
      alu_t o;
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      o = '0;
      case (op)
         4'd0: begin t = ua + ub; o.r = t[31:0]; o.c = (t >= TWO32); end
         4'd1: begin t = ua - ub; o.r = t[31:0]; o.c = (ua < ub); end
         4'd2: begin t = sa + sb; o.r = t[31:0]; o.v = (t > MAXS) || (t < MINS); end
         4'd3: begin t = sa - sb; o.r = t[31:0]; o.v = (t > MAXS) || (t < MINS); end
         4'd4: o.r = a & b;
         4'd5: o.r = a | b;
         4'd6: o.r = a ^ b;
         4'd7: o.r = ~(a | b);
         4'd8, 4'd9: begin t = ub * 65536; o.r = t[31:0]; end
         4'd10: o.r = (ua < ub) ? 32'd1 : 32'd0;
         4'd11: o.r = (sa < sb) ? 32'd1 : 32'd0;
         4'd12: begin t = sb >>> a[4:0]; o.r = t[31:0]; end
         4'd13: o.r = b >> a[4:0];
         default: o.r = b << a[4:0];
      endcase
      return o;
   endfunction

   // Would vector i be counted as failing under a given ALU fault?
   function automatic bit vec_bad(input int mode, input int row, input int i);
      alu_t g;
      bit cy_op, ov_op;
      g = ref_alu(va[i], vb[i], vop[i]);
      cy_op = (vop[i] == 4'd0) || (vop[i] == 4'd1);
      ov_op = (vop[i] == 4'd2) || (vop[i] == 4'd3);
      case (mode)
         1: return (vop[i] == 4'd4) && ((va[i] & vb[i]) != 32'h0);
         2: return ov_op && g.v;
         4: return (bad_kind[row][i] == 2'd1) || (bad_kind[row][i] == 2'd2 && cy_op)
                || (bad_kind[row][i] == 2'd3 && ov_op);
         5: return (g.r != 32'h0) || (cy_op && g.c) || (ov_op && g.v);
         default: return 1'b0;
      endcase
   endfunction

   // Behavioural ALU feeding the main instance, with selectable faults
   always_comb begin
      alu_t g;
      g = ref_alu(m_a, m_b, m_aluc);
      m_r = g.r;
      m_c = g.c;
      m_v = g.v;
      case (fault)
         1: if (m_aluc == 4'd4 && (m_a & m_b) != 32'h0) m_r = 32'h0;
         2: m_v = 1'b0;
         3: if (m_aluc >= 4'd4) m_c = 1'b1;
         4: case (bad_kind[cur_row][m_idx[5:0]])
               2'd1: m_r = m_r ^ flip[cur_row];
               2'd2: m_c = ~m_c;
               2'd3: m_v = ~m_v;
               default: ;
            endcase
         default: ;
      endcase
      m_zero = (m_r == 32'h0);
      m_neg  = m_r[31];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Pulse (or hold) start, then follow the run checking the vector stream
   task automatic run_main(input bit hold, output int k, output int seq_bad);
      start_m = 1'b1;
      tick();
      if (!hold) start_m = 1'b0;
      k = 0;
      seq_bad = 0;
      while (!m_done && k < NV + 8) begin
         if (k >= NV || m_busy !== 1'b1 || m_idx !== 16'(k) || m_a !== va[k]
             || m_b !== vb[k] || m_aluc !== vop[k])
            seq_bad++;
         tick();
         k++;
      end
   endtask

   task automatic check_result(input string tag, input int exp_err, input int first);
      logic [31:0] ea, eb;
      logic [3:0]  eop;
      ea = 32'h0; eb = 32'h0; eop = 4'h0;
      if (first >= 0) begin ea = va[first]; eb = vb[first]; eop = vop[first]; end
      chk({tag, "_err"}, m_err, 64'(exp_err));
      chk({tag, "_pass"}, m_pass, (exp_err == 0));
      chk({tag, "_busy_done"}, {m_busy, m_done}, 2'b01);
      chk({tag, "_fail_vec"}, {m_fa, m_fb, m_faluc}, {ea, eb, eop});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] q;
      int k, sb, cnt, first, prev, sat_bad, exp1, first1;
      rst = 1'b1; start_m = 1'b0; start_s = 1'b0; fault = 0; cur_row = 0;

      q = (SEED == 32'h0) ? 32'h1 : SEED;
      for (int i = 0; i < NV; i++) begin
         q = lfsr(q); va[i] = q;
         q = lfsr(q); vb[i] = q;
         vop[i] = 4'(i % 16);
      end
      for (int r = 0; r < NCASE; r++) begin
         flip[r] = 32'h1 << $urandom_range(0, 31);
         for (int i = 0; i < NV; i++)
            bad_kind[r][i] = (r >= 4 && $urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      end
      cases[0] = '{"clean", 0, 0, -1};
      cases[1] = '{"and_fault", 1, 0, -1};
      cases[2] = '{"ovf_stuck", 2, 0, -1};
      cases[3] = '{"carry_dontcare", 3, 0, -1};
      cases[4] = '{"rand_a", 4, 0, -1};
      cases[5] = '{"rand_b", 4, 0, -1};
      cases[6] = '{"rand_c", 4, 0, -1};
      for (int r = 0; r < NCASE; r++) begin
         cnt = 0; first = -1;
         for (int i = 0; i < NV; i++)
            if (vec_bad(cases[r].mode, r, i)) begin
               cnt++;
               if (first < 0) first = i;
            end
         cases[r].exp_err = cnt;
         cases[r].first   = first;
      end
      exp1   = cases[1].exp_err;
      first1 = cases[1].first;

      // Reset state
      tick(); tick();
      chk("rst_status", {m_busy, m_done, m_pass, m_err, m_idx}, 64'h0);
      chk("rst_alu_regs", {m_a, m_b}, 64'h0);
      chk("rst_fail_regs", {m_fa, m_fb[27:0], m_aluc, m_faluc}, 64'h0);
      rst = 1'b0;
      tick();
      chk("idle_no_start", {m_busy, m_done, s_busy, s_done}, 64'h0);

      // Table-driven runs
      for (int r = 0; r < NCASE; r++) begin
         fault = cases[r].mode;
         cur_row = r;
         run_main(1'b0, k, sb);
         chk({cases[r].name, "_latency"}, 64'(k), 64'(NV));
         chk({cases[r].name, "_vec_seq"}, 64'(sb), 64'h0);
         check_result(cases[r].name, cases[r].exp_err, cases[r].first);
      end

      // DONE holds outputs without start
      tick(); tick();
      chk("done_hold", {m_busy, m_done, m_idx}, {2'b01, 16'(NV - 1)});

      // Reset in the middle of a run, then an identical rerun
      fault = 1; cur_row = 1;
      start_m = 1'b1; tick(); start_m = 1'b0;
      k = 0;
      while (m_idx != 16'd5 && k < 20) begin tick(); k++; end
      chk("mid_reach_idx5", m_idx, 64'd5);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_status", {m_busy, m_done, m_pass, m_err, m_idx}, 64'h0);
      chk("mid_rst_alu", {m_a, m_b}, 64'h0);
      chk("mid_rst_aluc_fail", {m_aluc, m_faluc, m_fa}, 64'h0);
      tick();
      rst = 1'b0;
      tick();
      chk("mid_rst_no_done", {m_busy, m_done}, 64'h0);
      run_main(1'b0, k, sb);
      chk("rerun_latency", 64'(k), 64'(NV));
      chk("rerun_vec_seq", 64'(sb), 64'h0);
      check_result("rerun", exp1, first1);

      // start held high through the run and into DONE
      run_main(1'b1, k, sb);
      chk("hold_latency", 64'(k), 64'(NV));
      chk("hold_vec_seq", 64'(sb), 64'h0);
      check_result("hold_first", exp1, first1);
      tick();
      chk("hold_restart", {m_busy, m_done, m_idx}, {2'b10, 16'h0});
      chk("hold_err_cleared", m_err, 64'h0);
      start_m = 1'b0;
      k = 0;
      while (!m_done && k < NV + 8) begin tick(); k++; end
      chk("hold_second_latency", 64'(k), 64'(NV));
      check_result("hold_second", exp1, first1);

      // Saturating error counter with a dead ALU
      cnt = 0; first = -1;
      for (int i = 0; i < NS; i++)
         if (vec_bad(5, 0, i)) begin
            cnt++;
            if (first < 0) first = i;
         end
      start_s = 1'b1; tick(); start_s = 1'b0;
      k = 0; prev = 0; sat_bad = 0;
      while (!s_done && k < NS + 8) begin
         tick(); k++;
         if (int'(s_err) < prev) sat_bad++;
         prev = int'(s_err);
      end
      chk("sat_latency", 64'(k), 64'(NS));
      chk("sat_err", s_err, 64'((cnt > 3) ? 3 : cnt));
      chk("sat_no_wrap", 64'(sat_bad), 64'h0);
      chk("sat_pass", {s_pass, s_busy, s_done}, {2'b00, (cnt == 0) ? 1'b0 : 1'b1} | {2'b00, 1'b1});
      if (first < 0) first = 0;
      chk("sat_fail_vec", {s_fa, s_fb}, {va[first], vb[first]});
      chk("sat_fail_aluc", s_faluc, 64'(vop[first]));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_bist.md
Name: alu_bist

Overview:
- Built-in self-test initiator for the 32-bit ALU: it drives operand and opcode vectors into the ALU's a/b/aluc inputs and checks the returned r/zero/carry/negative/overflow against an internal golden model.
- Sits beside the ALU in the single-cycle CPU and takes ownership of the ALU inputs while busy; the CPU-side mux selects the bist outputs while busy=1.
- Vectors come from a 32-bit LFSR; aluc sweeps all 16 codes.

Parameters:
- NUM_VEC, 256, number of vectors per run (≥1, ≤65535).
- SEED, 32'hACE12345, LFSR seed; a seed of 0 is replaced by 32'h1.
- ERR_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  begin a run; honoured only in IDLE or DONE
- alu_a  output  32  operand a to ALU (registered)
- alu_b  output  32  operand b to ALU (registered)
- alu_aluc  output  4  opcode to ALU (registered)
- alu_r  input  32  ALU result
- alu_zero, alu_carry, alu_negative, alu_overflow  input  1 each  ALU flags
- busy  output  1  run in progress
- done  output  1  run complete; held until next start or reset
- pass  output  1  done and err_count==0
- err_count  output  ERR_W  mismatching vectors, saturating
- fail_a, fail_b  output  32 each  operands of the first failing vector
- fail_aluc  output  4  opcode of the first failing vector
- vec_idx  output  16  index of the vector currently on alu_*

Behaviour:
- Reset (async): state IDLE; all outputs 0; LFSR=SEED (or 1 if SEED is 0).
- LFSR: Fibonacci, shift left, new bit = q[31]^q[21]^q[1]^q[0]. It advances twice per vector: first value to a, second to b.
- The LFSR is reloaded from SEED at every start, so runs are repeatable.
- IDLE/DONE with start=1:
  - clear err_count, fail_*, done, pass;
  - load vector 0 (aluc=0, a, b from LFSR); vec_idx=0; busy=1; go to CHECK.
- CHECK, one cycle per vector (the ALU is combinational, so its inputs are valid in the same cycle):
  - compare the ALU outputs against the golden model of the current alu_* registers;
  - on mismatch, err_count++ (saturating at all-ones);
  - if this is the first mismatch, capture fail_a, fail_b and fail_aluc;
  - if vec_idx==NUM_VEC-1: busy=0, done=1, pass=(err_count_next==0), go to DONE;
  - otherwise load the next vector with aluc=(vec_idx+1)[3:0] and vec_idx++.
- Latency: done rises on exactly the NUM_VEC-th rising edge after the edge that samples start.
- start while in CHECK is ignored. start held high in DONE restarts the run on the next edge.
- In IDLE and DONE the alu_* outputs hold their last values.
- Golden model (shift amount is a[4:0]):
  - 0000 addu a+b
  - 0010 add a+b
  - 0001 subu a-b
  - 0011 sub a-b
  - 0100 and
  - 0101 or
  - 0110 xor
  - 0111 nor
  - 100x lui: {b[15:0],16'h0}
  - 1011 slt: signed a<b ? 1 : 0
  - 1010 sltu: unsigned a<b ? 1 : 0
  - 1100 sra: $signed(b)>>>sh
  - 1101 srl: b>>sh
  - 111x sll: b<<sh
- Checked fields:
  - r, zero=(r==0) and negative=r[31]: always.
  - carry: only for 0000 (bit 32 of the 33-bit sum) and 0001 (unsigned borrow, a<b).
  - overflow: only for 0010 and 0011 (signed overflow of the add/sub).
  - All other flag fields are don't-care.
- A vector fails if any checked field differs.
- Reset mid-run: returns immediately to IDLE with all outputs 0; no partial done.

Test Plan:
- Correct ALU model, NUM_VEC=16, start pulsed 1 cycle -> busy high for 16 cycles; done rises on edge 16 after start; pass=1, err_count=0; aluc sequence 0..15.
- ALU model with the AND result forced to 0 when a&b≠0, NUM_VEC=256 -> err_count equals the number of 0100 vectors with a&b≠0 (expect 16 for the LFSR data); fail_aluc=4'b0100; fail_a/fail_b equal the first such vector; pass=0.
- ALU model with the overflow flag stuck at 0 -> only 0010/0011 vectors with true signed overflow counted; a stuck carry on 0100..1111 is not counted.
- ERR_W=2, ALU output stuck at 32'h0 -> err_count saturates at 3 and does not wrap; fail_* hold vector 0.
- rst asserted at vec_idx=5 -> all outputs 0 asynchronously; a new start gives results identical to an uninterrupted run (same SEED).
- start held high through the run and into DONE -> no effect mid-run; a second run starts the edge after done; err_count is re-cleared.
